ctrl_decode_stage: RTL and testbench
====================================

# ctrl_decode_stage

Registered, flow-controlled instruction decode stage for the 9-bit ISA. It sits between instruction fetch and register-file read. It decodes one instruction per cycle into the control bundle and holds the result in an output register behind a valid/ready handshake. Beyond plain decoding it keeps the branch-flag register, inserts a load-use bubble, supports flush, and counts illegal opcodes.

## Interface
- ALUW, 5: ALUOp width; must be ≥5; codes are zero-extended into it, "error" code is all ones.
- STALL_EN, 1: 1 enables the load-use hazard bubble; 0 removes it (InstrReady ignores hazards).
- ERRW, 8: width of the illegal-instruction counter.
- Clk  in  1  clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous; kills the output register and refuses input this cycle.
- InstrValid  in  1  fetch presents Instr.
- Instr  in  9  instruction word.
- InstrReady  out  1  stage accepts Instr this cycle.
- OutValid  out  1  control bundle valid.
- OutReady  in  1  downstream consumes bundle.
- Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, FlagWrite, Immed, Illegal  out  1 each  registered control bits.
- Flag  out  3  registered flag field of the instruction.
- ReadAddr1, ReadAddr2, WriteAddr  out  4 each  registered register addresses.
- ALUOp  out  ALUW  registered ALU operation.
- FlagQ  out  3  architectural branch-flag register.
- IllegalCnt  out  ERRW  saturating count of accepted illegal instructions.
- Stall  out  1  combinational: hazard is currently blocking input.

## Operation
- Decode defaults: ReadAddr1=8, ReadAddr2=9, WriteAddr=0, ALUOp=all ones, all 1-bit controls 0, Flag=0. Priority is top-down.
- Instr[8]=1 (mov): RA1=RA2=Instr[3:0], WA=Instr[7:4], ALUOp=2, RegWrite.
- Instr[8:6]=010 (b): Branch, Immed.
- Instr[8:5]=0110 (li): Immed, RegWrite, WA=15.
- Instr[8:3]=000111 (sbf): sub-codes 0..4 set FlagWrite and Flag=Instr[2:0]. Sub-codes 5..7 are illegal.
- Instr[8:6]=000, Instr[5:3]≠111 (compute): WA={0,Instr[2:0]}, RegWrite, ALUOp=Instr[5:3].
- Instr[8:6]=001, Instr[4]=0 (shift): WA={1,0,0,Instr[3]}, RegWrite, ALUSrc=(Instr[2:0]≠0), ALUOp=14 (lsl, Instr[3]=0) or 15 (lsr).
- Instr[8:4]=00101: RA1=RA2={0,Instr[2:0]}, ALUOp=2.
  - lb (Instr[3]=0): WA=15, RegWrite, MemtoReg.
  - sb (Instr[3]=1): MemWrite.
- Anything else: defaults plus Illegal=1.
- Accept = InstrValid & InstrReady. The bundle registers load only on accept.
- InstrReady = !Flush & (!OutValid | OutReady) & !Stall.
- Hazard when STALL_EN=1 and all three hold:
  - OutValid is set and the held bundle is lb (MemtoReg=1);
  - InstrValid is set;
  - the incoming instruction reads r15, i.e. mov with Instr[3:0]=15, or sb.
- Stall = hazard.
- FlagQ ← Instr[2:0] on accept of a legal sbf. Flushed or refused sbf has no effect.
- IllegalCnt increments on accept of an illegal instruction and saturates at all ones. Illegal instructions still flow downstream with all write enables 0.

## Timing
- Reset values:
  - OutValid=0, FlagQ=0, IllegalCnt=0.
  - Bundle: RA1=8, RA2=9, WA=0, ALUOp=all ones, all 1-bit controls and Flag=0.
  - Stall follows its inputs (0 after reset since OutValid=0).
- Latency 1: an instruction accepted at edge N is visible with OutValid=1 after edge N. Throughput is 1 per cycle.
- Output register update per edge:
  - accept → OutValid=1;
  - else OutValid & OutReady → OutValid=0, bundle holds its stale value;
  - else hold.
- OutValid & !OutReady: bundle and OutValid are stable until consumed.
- Load-use: a lb followed by a hazardous instruction with OutReady=1 produces exactly one OutValid=0 cycle between them. With OutReady=0 the stall lasts until the lb drains, then one bubble follows.
- Flush has priority over everything: OutValid=0 after the edge, no accept, FlagQ and IllegalCnt unchanged.
- Flush during a hazard clears the hazard on the next cycle.
- Reset_n assertion mid-operation clears all state immediately, without waiting for a clock edge. The first accept can occur on the first edge after deassertion.

## Test plan
- Reset, then stream mov r9←r3 (1_1001_0011), li, b, compute add(000_000_010) with OutReady=1. Required: one bundle per cycle, 1-cycle latency, WA=9/15/—/2, ALUOp=2/all-ones/all-ones/0.
- Backpressure: hold OutReady=0 for 3 cycles with InstrValid=1. Required: InstrReady=0, bundle stable; on release, no instruction is lost or duplicated.
- lb r2 (0_0101_0010) then mov r4←r15 (1_0100_1111), STALL_EN=1. Required: Stall=1 for one cycle and one bubble. With STALL_EN=0: no bubble.
- sbf codes 3, then 6, then 4. Required: FlagQ=3, then unchanged with Illegal=1 and IllegalCnt=1, then FlagQ=4.
- Flush asserted on the cycle an sbf 2 is presented. Required: FlagQ is not updated, OutValid=0 next cycle, and the sbf is re-accepted once Flush drops.
- ERRW=2: feed 5 illegal words 0_0111_0000. Required: IllegalCnt saturates at 3. Then assert Reset_n=0 mid-stream: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered, flow-controlled decode stage for the 9-bit ISA.
// Decodes one instruction per cycle into a control bundle held behind a
// valid/ready output register, maintains the branch-flag register, inserts a
// load-use bubble when a held lb feeds an instruction that reads r15, and
// keeps a saturating count of accepted illegal instructions.
module ctrl_decode_stage #(
    parameter int   ALUW     = 5,
    parameter logic STALL_EN = 1'b1,
    parameter int   ERRW     = 8
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Flush,
    input  logic            InstrValid,
    input  logic [8:0]      Instr,
    output logic            InstrReady,
    output logic            OutValid,
    input  logic            OutReady,
    output logic            Branch,
    output logic            MemtoReg,
    output logic            MemWrite,
    output logic            ALUSrc,
    output logic            RegWrite,
    output logic            FlagWrite,
    output logic            Immed,
    output logic            Illegal,
    output logic [2:0]      Flag,
    output logic [3:0]      ReadAddr1,
    output logic [3:0]      ReadAddr2,
    output logic [3:0]      WriteAddr,
    output logic [ALUW-1:0] ALUOp,
    output logic [2:0]      FlagQ,
    output logic [ERRW-1:0] IllegalCnt,
    output logic            Stall
);

    // Decoded (next) bundle values for the instruction currently presented.
    logic            branch_next, memtoreg_next, memwrite_next, alusrc_next;
    logic            regwrite_next, flagwrite_next, immed_next, illegal_next;
    logic [2:0]      flag_next;
    logic [3:0]      ra1_next, ra2_next, wa_next;
    logic [ALUW-1:0] aluop_next;

    // Output register contents.
    logic            valid_reg;
    logic            branch_reg, memtoreg_reg, memwrite_reg, alusrc_reg;
    logic            regwrite_reg, flagwrite_reg, immed_reg, illegal_reg;
    logic [2:0]      flag_reg;
    logic [3:0]      ra1_reg, ra2_reg, wa_reg;
    logic [ALUW-1:0] aluop_reg;

    logic [2:0]      flagq_reg;
    logic [ERRW-1:0] illegal_cnt_reg;

    logic            reads_r15;
    logic            hazard;
    logic            accept;

    // Combinational decode; branches are ordered so earlier patterns win.
    always_comb begin
        branch_next    = 1'b0;
        memtoreg_next  = 1'b0;
        memwrite_next  = 1'b0;
        alusrc_next    = 1'b0;
        regwrite_next  = 1'b0;
        flagwrite_next = 1'b0;
        immed_next     = 1'b0;
        illegal_next   = 1'b0;
        flag_next      = 3'd0;
        ra1_next       = 4'd8;
        ra2_next       = 4'd9;
        wa_next        = 4'd0;
        aluop_next     = '1;
        if (Instr[8]) begin
            // mov rd <- rs
            ra1_next      = Instr[3:0];
            ra2_next      = Instr[3:0];
            wa_next       = Instr[7:4];
            aluop_next    = ALUW'(2);
            regwrite_next = 1'b1;
        end else if (Instr[7:6] == 2'b10) begin
            // b
            branch_next = 1'b1;
            immed_next  = 1'b1;
        end else if (Instr[7:5] == 3'b110) begin
            // li: immediate into r15
            immed_next    = 1'b1;
            regwrite_next = 1'b1;
            wa_next       = 4'd15;
        end else if (Instr[7:3] == 5'b00111) begin
            // sbf: only flag sub-codes 0..4 exist
            if (Instr[2:0] <= 3'd4) begin
                flagwrite_next = 1'b1;
                flag_next      = Instr[2:0];
            end else begin
                illegal_next = 1'b1;
            end
        end else if (Instr[7:6] == 2'b00) begin
            // compute: Instr[5:3] != 7 is guaranteed by the sbf branch above
            wa_next       = {1'b0, Instr[2:0]};
            regwrite_next = 1'b1;
            aluop_next    = ALUW'(Instr[5:3]);
        end else if (Instr[7:6] == 2'b01 && !Instr[4]) begin
            // shift: lsl (Instr[3]=0) / lsr (Instr[3]=1), zero amount uses reg operand
            wa_next       = {3'b100, Instr[3]};
            regwrite_next = 1'b1;
            alusrc_next   = (Instr[2:0] != 3'd0);
            aluop_next    = Instr[3] ? ALUW'(15) : ALUW'(14);
        end else if (Instr[7:4] == 4'b0101) begin
            // lb / sb with base register {0, Instr[2:0]}
            ra1_next   = {1'b0, Instr[2:0]};
            ra2_next   = {1'b0, Instr[2:0]};
            aluop_next = ALUW'(2);
            if (!Instr[3]) begin
                wa_next       = 4'd15;
                regwrite_next = 1'b1;
                memtoreg_next = 1'b1;
            end else begin
                memwrite_next = 1'b1;
            end
        end else begin
            illegal_next = 1'b1;
        end
    end

    // Incoming instructions that consume r15: mov from r15, and every sb.
    assign reads_r15 = (Instr[8] && Instr[3:0] == 4'hF) || (Instr[8:3] == 6'b001011);

    generate
        if (STALL_EN) begin : g_hazard
            assign hazard = valid_reg & memtoreg_reg & InstrValid & reads_r15;
        end else begin : g_no_hazard
            assign hazard = 1'b0;
        end
    endgenerate

    assign Stall      = hazard;
    assign InstrReady = !Flush && (!valid_reg || OutReady) && !hazard;
    assign accept     = InstrValid && InstrReady;

    // Output-valid flag: flush kills, accept sets, consumption clears.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_reg <= 1'b0;
        end else if (Flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg <= 1'b1;
        end else if (valid_reg && OutReady) begin
            valid_reg <= 1'b0;
        end
    end

    // Bundle register loads only on accept; otherwise keeps its (possibly stale) value.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            branch_reg    <= 1'b0;
            memtoreg_reg  <= 1'b0;
            memwrite_reg  <= 1'b0;
            alusrc_reg    <= 1'b0;
            regwrite_reg  <= 1'b0;
            flagwrite_reg <= 1'b0;
            immed_reg     <= 1'b0;
            illegal_reg   <= 1'b0;
            flag_reg      <= 3'd0;
            ra1_reg       <= 4'd8;
            ra2_reg       <= 4'd9;
            wa_reg        <= 4'd0;
            aluop_reg     <= '1;
        end else if (accept) begin
            branch_reg    <= branch_next;
            memtoreg_reg  <= memtoreg_next;
            memwrite_reg  <= memwrite_next;
            alusrc_reg    <= alusrc_next;
            regwrite_reg  <= regwrite_next;
            flagwrite_reg <= flagwrite_next;
            immed_reg     <= immed_next;
            illegal_reg   <= illegal_next;
            flag_reg      <= flag_next;
            ra1_reg       <= ra1_next;
            ra2_reg       <= ra2_next;
            wa_reg        <= wa_next;
            aluop_reg     <= aluop_next;
        end
    end

    // Architectural branch-flag register, written by accepted legal sbf only.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flagq_reg <= 3'd0;
        end else if (accept && flagwrite_next) begin
            flagq_reg <= flag_next;
        end
    end

    // Saturating illegal-instruction counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            illegal_cnt_reg <= '0;
        end else if (accept && illegal_next && (illegal_cnt_reg != '1)) begin
            illegal_cnt_reg <= illegal_cnt_reg + ERRW'(1);
        end
    end

    assign OutValid   = valid_reg;
    assign Branch     = branch_reg;
    assign MemtoReg   = memtoreg_reg;
    assign MemWrite   = memwrite_reg;
    assign ALUSrc     = alusrc_reg;
    assign RegWrite   = regwrite_reg;
    assign FlagWrite  = flagwrite_reg;
    assign Immed      = immed_reg;
    assign Illegal    = illegal_reg;
    assign Flag       = flag_reg;
    assign ReadAddr1  = ra1_reg;
    assign ReadAddr2  = ra2_reg;
    assign WriteAddr  = wa_reg;
    assign ALUOp      = aluop_reg;
    assign FlagQ      = flagq_reg;
    assign IllegalCnt = illegal_cnt_reg;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Testbench for ctrl_decode_stage: scoreboard of expected bundles pushed on
// accept and popped as the stage hands bundles downstream.
module tb_ctrl_decode_stage;

    logic       Clk;
    logic       Reset_n;
    logic       Flush;
    logic       InstrValid;
    logic [8:0] Instr;
    logic       OutReady;

    logic       InstrReady, OutValid, Stall;
    logic       Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, FlagWrite, Immed, Illegal;
    logic [2:0] Flag, FlagQ;
    logic [3:0] ReadAddr1, ReadAddr2, WriteAddr;
    logic [4:0] ALUOp;
    logic [1:0] IllegalCnt;

    // second instance with the hazard bubble disabled
    logic       ns_InstrReady, ns_OutValid, ns_Stall;
    logic       ns_Branch, ns_MemtoReg, ns_MemWrite, ns_ALUSrc, ns_RegWrite;
    logic       ns_FlagWrite, ns_Immed, ns_Illegal;
    logic [2:0] ns_Flag, ns_FlagQ;
    logic [3:0] ns_ReadAddr1, ns_ReadAddr2, ns_WriteAddr;
    logic [4:0] ns_ALUOp;
    logic [7:0] ns_IllegalCnt;

    ctrl_decode_stage #(.ALUW(5), .STALL_EN(1'b1), .ERRW(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .InstrValid(InstrValid),
        .Instr(Instr), .InstrReady(InstrReady), .OutValid(OutValid), .OutReady(OutReady),
        .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .FlagWrite(FlagWrite), .Immed(Immed), .Illegal(Illegal),
        .Flag(Flag), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .WriteAddr(WriteAddr),
        .ALUOp(ALUOp), .FlagQ(FlagQ), .IllegalCnt(IllegalCnt), .Stall(Stall)
    );

    ctrl_decode_stage #(.ALUW(5), .STALL_EN(1'b0), .ERRW(8)) dut_ns (
        .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .InstrValid(InstrValid),
        .Instr(Instr), .InstrReady(ns_InstrReady), .OutValid(ns_OutValid), .OutReady(OutReady),
        .Branch(ns_Branch), .MemtoReg(ns_MemtoReg), .MemWrite(ns_MemWrite), .ALUSrc(ns_ALUSrc),
        .RegWrite(ns_RegWrite), .FlagWrite(ns_FlagWrite), .Immed(ns_Immed), .Illegal(ns_Illegal),
        .Flag(ns_Flag), .ReadAddr1(ns_ReadAddr1), .ReadAddr2(ns_ReadAddr2), .WriteAddr(ns_WriteAddr),
        .ALUOp(ns_ALUOp), .FlagQ(ns_FlagQ), .IllegalCnt(ns_IllegalCnt), .Stall(ns_Stall)
    );

    localparam logic [8:0] I_MOV93  = 9'b1_1001_0011;
    localparam logic [8:0] I_LI     = 9'b0_1100_0101;
    localparam logic [8:0] I_B      = 9'b0_1000_0111;
    localparam logic [8:0] I_ADD    = 9'b0_0000_0010;
    localparam logic [8:0] I_LSR    = 9'b0_0100_1011;
    localparam logic [8:0] I_LSL    = 9'b0_0100_0000;
    localparam logic [8:0] I_LB2    = 9'b0_0101_0010;
    localparam logic [8:0] I_SB3    = 9'b0_0101_1011;
    localparam logic [8:0] I_MOV415 = 9'b1_0100_1111;
    localparam logic [8:0] I_MOV43  = 9'b1_0100_0011;
    localparam logic [8:0] I_ILL    = 9'b0_0111_0000;

    int total = 0;
    int bad   = 0;

    logic [27:0] sb_q[$];
    logic [27:0] mon_exp;
    logic [27:0] obs;
    int n_sent = 0, n_rx = 0, n_drop = 0;
    int last_waits;
    logic first_stall, first_ns_stall, first_ns_ready, ov_at_accept;
    int exp_cnt;

    assign obs = {Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, FlagWrite, Immed, Illegal,
                  Flag, ReadAddr1, ReadAddr2, WriteAddr, ALUOp};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count one comparison and report it when it mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ctl = {Branch,MemtoReg,MemWrite,ALUSrc,RegWrite,FlagWrite,Immed,Illegal}
    function automatic logic [27:0] mk(input logic [7:0] ctl, input logic [2:0] flag,
                                       input logic [3:0] ra1, input logic [3:0] ra2,
                                       input logic [3:0] wa, input logic [4:0] aluop);
        return {ctl, flag, ra1, ra2, wa, aluop};
    endfunction

    // Present one instruction from the next falling edge until it is accepted.
    task automatic send(input logic [8:0] ins, input logic [27:0] exp, input logic ordy);
        int waits;
        waits = 0;
        @(negedge Clk);
        Flush      = 1'b0;
        OutReady   = ordy;
        Instr      = ins;
        InstrValid = 1'b1;
        #1;
        first_stall    = Stall;
        first_ns_stall = ns_Stall;
        first_ns_ready = ns_InstrReady;
        while (!InstrReady && waits < 20) begin
            @(negedge Clk);
            #1;
            waits++;
        end
        if (InstrReady) begin
            sb_q.push_back(exp);
            n_sent++;
            ov_at_accept = OutValid;
            $display("tx %0d instr=%b waits=%0d", n_sent, ins, waits);
        end else begin
            check("send_timeout", 32'(InstrReady), 1);
        end
        last_waits = waits;
        @(posedge Clk);
    endtask

    task automatic idle();
        @(negedge Clk);
        InstrValid = 1'b0;
    endtask

    // Monitor: pop and compare each bundle consumed downstream.
    initial begin
        forever begin
            @(negedge Clk);
            #2;
            if (Reset_n && OutValid && OutReady) begin
                check("q_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    mon_exp = sb_q.pop_front();
                    n_rx++;
                    check("bundle", 32'(obs), 32'(mon_exp));
                    $display("rx %0d bundle=%h exp=%h", n_rx, obs, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; Flush = 1'b0; InstrValid = 1'b0; Instr = 9'd0; OutReady = 1'b1;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check("rst_outvalid", 32'(OutValid), 0);
        check("rst_flagq", 32'(FlagQ), 0);
        check("rst_cnt", 32'(IllegalCnt), 0);
        check("rst_bundle", 32'(obs), 32'(mk(8'h00, 3'd0, 4'd8, 4'd9, 4'd0, 5'd31)));
        check("rst_stall", 32'(Stall), 0);
        check("rst_ready", 32'(InstrReady), 1);

        // Streaming at full rate
        send(I_MOV93, mk(8'b0000_1000, 3'd0, 4'd3, 4'd3, 4'd9, 5'd2), 1'b1);
        check("mov_waits", last_waits, 0);
        check("mov_ov_pre", 32'(ov_at_accept), 0);
        send(I_LI, mk(8'b0000_1010, 3'd0, 4'd8, 4'd9, 4'd15, 5'd31), 1'b1);
        check("li_waits", last_waits, 0);
        check("li_ov_pre", 32'(ov_at_accept), 1);
        send(I_B, mk(8'b1000_0010, 3'd0, 4'd8, 4'd9, 4'd0, 5'd31), 1'b1);
        check("b_waits", last_waits, 0);
        send(I_ADD, mk(8'b0000_1000, 3'd0, 4'd8, 4'd9, 4'd2, 5'd0), 1'b1);
        check("add_waits", last_waits, 0);

        // Backpressure: three cycles with the add bundle held
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            OutReady = 1'b0; InstrValid = 1'b1; Instr = I_LSR;
            #1;
            check("bp_ready", 32'(InstrReady), 0);
            check("bp_valid", 32'(OutValid), 1);
            check("bp_hold", 32'(obs), 32'(sb_q[0]));
        end
        send(I_LSR, mk(8'b0001_1000, 3'd0, 4'd8, 4'd9, 4'd9, 5'd15), 1'b1);
        check("bp_release_waits", last_waits, 0);
        send(I_LSL, mk(8'b0000_1000, 3'd0, 4'd8, 4'd9, 4'd8, 5'd14), 1'b1);

        // Load-use hazards
        send(I_LB2, mk(8'b0100_1000, 3'd0, 4'd2, 4'd2, 4'd15, 5'd2), 1'b1);
        send(I_MOV415, mk(8'b0000_1000, 3'd0, 4'd15, 4'd15, 4'd4, 5'd2), 1'b1);
        check("lu_mov_waits", last_waits, 1);
        check("lu_mov_stall", 32'(first_stall), 1);
        check("lu_bubble", 32'(ov_at_accept), 0);
        check("ns_stall", 32'(first_ns_stall), 0);
        check("ns_ready", 32'(first_ns_ready), 1);
        send(I_LB2, mk(8'b0100_1000, 3'd0, 4'd2, 4'd2, 4'd15, 5'd2), 1'b1);
        send(I_SB3, mk(8'b0010_0000, 3'd0, 4'd3, 4'd3, 4'd0, 5'd2), 1'b1);
        check("lu_sb_waits", last_waits, 1);
        send(I_LB2, mk(8'b0100_1000, 3'd0, 4'd2, 4'd2, 4'd15, 5'd2), 1'b1);
        send(I_MOV43, mk(8'b0000_1000, 3'd0, 4'd3, 4'd3, 4'd4, 5'd2), 1'b1);
        check("nohz_waits", last_waits, 0);
        check("nohz_stall", 32'(first_stall), 0);

        // sbf 3, 6 (illegal), 4
        send(9'b0_0011_1011, mk(8'b0000_0100, 3'd3, 4'd8, 4'd9, 4'd0, 5'd31), 1'b1);
        #1 check("sbf3_flagq", 32'(FlagQ), 3);
        send(9'b0_0011_1110, mk(8'b0000_0001, 3'd0, 4'd8, 4'd9, 4'd0, 5'd31), 1'b1);
        #1 check("sbf6_flagq", 32'(FlagQ), 3);
        check("sbf6_cnt", 32'(IllegalCnt), 1);
        send(9'b0_0011_1100, mk(8'b0000_0100, 3'd4, 4'd8, 4'd9, 4'd0, 5'd31), 1'b1);
        #1 check("sbf4_flagq", 32'(FlagQ), 4);

        // Flush kills the held sbf4 bundle and refuses sbf 2
        @(negedge Clk);
        OutReady = 1'b0; Flush = 1'b1; InstrValid = 1'b1; Instr = 9'b0_0011_1010;
        #1;
        check("flush_ready", 32'(InstrReady), 0);
        check("flush_pre_valid", 32'(OutValid), 1);
        void'(sb_q.pop_front());
        n_drop++;
        @(negedge Clk);
        Flush = 1'b0; OutReady = 1'b1; InstrValid = 1'b0;
        #1;
        check("flush_valid", 32'(OutValid), 0);
        check("flush_flagq", 32'(FlagQ), 4);
        send(9'b0_0011_1010, mk(8'b0000_0100, 3'd2, 4'd8, 4'd9, 4'd0, 5'd31), 1'b1);
        #1 check("sbf2_flagq", 32'(FlagQ), 2);

        // Illegal counter saturates at 3 with ERRW=2
        exp_cnt = 1;
        for (int i = 0; i < 5; i++) begin
            send(I_ILL, mk(8'b0000_0001, 3'd0, 4'd8, 4'd9, 4'd0, 5'd31), 1'b1);
            exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
            #1 check("ill_cnt", 32'(IllegalCnt), 32'(exp_cnt));
        end

        // Asynchronous reset mid-stream, between clock edges
        @(negedge Clk);
        OutReady = 1'b0; InstrValid = 1'b1; Instr = I_MOV93;
        #3 Reset_n = 1'b0;
        #1;
        check("arst_outvalid", 32'(OutValid), 0);
        check("arst_flagq", 32'(FlagQ), 0);
        check("arst_cnt", 32'(IllegalCnt), 0);
        check("arst_bundle", 32'(obs), 32'(mk(8'h00, 3'd0, 4'd8, 4'd9, 4'd0, 5'd31)));
        check("arst_stall", 32'(Stall), 0);
        n_drop += sb_q.size();
        sb_q.delete();
        InstrValid = 1'b0; OutReady = 1'b1;
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        send(I_MOV93, mk(8'b0000_1000, 3'd0, 4'd3, 4'd3, 4'd9, 5'd2), 1'b1);
        check("post_rst_waits", last_waits, 0);
        idle();
        repeat (3) @(negedge Clk);
        #3;
        check("q_drained", 32'(sb_q.size()), 0);
        check("no_loss", 32'(n_rx), 32'(n_sent - n_drop));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
